mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master memory arbiter for the dual-core CPU. It sits directly downstream of both `mips` cores. It takes each core's `memread`/`memwrite`/`adr`/`writedata`, serialises the accesses onto the single shared memory port, and returns each core's `grant` and `memdata`. Arbitration is round-robin, one access in flight at a time, with a ready handshake to memory.

## Interface
- WIDTH, 8, data and address width; matches the core's WIDTH.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- memread0, memwrite0  input  1 each  core 0 request strobes; held until grant0.
- adr0, writedata0  input  WIDTH each  core 0 address and write data; stable while requesting.
- memread1, memwrite1, adr1, writedata1  input  1/1/WIDTH/WIDTH  core 1 equivalents.
- grant0, grant1  output  1 each  one-cycle completion pulse to the served core.
- memdata0, memdata1  output  WIDTH each  registered read data per core.
- mem_en  output  1  access request to memory.
- mem_we  output  1  write qualifier, valid while mem_en is high.
- mem_adr, mem_wdata  output  WIDTH each  registered address and write data.
- mem_rdata  input  WIDTH  memory read data, valid when mem_ready is high.
- mem_ready  input  1  memory completion; sampled only in ACCESS.

## Operation
- A core requests when memread or memwrite is high. If both are high, the access is treated as a write.
- The FSM has three states: IDLE, ACCESS and GRANT.
- IDLE:
  - With no request, stay in IDLE.
  - With a request, choose the winner, latch its address, write data, write flag and id into the mem_* registers, and go to ACCESS.
- Round-robin selection uses `last`, the id of the most recently granted core.
  - If only one core requests, it wins.
  - If both request, the core not equal to `last` wins.
  - `last` updates when the arbiter enters GRANT.
- ACCESS:
  - mem_en is 1; mem_adr, mem_wdata and mem_we hold constant.
  - When mem_ready is 1: on a read, capture mem_rdata into memdata[id]; on a write, memdata[id] is unchanged. Then go to GRANT.
  - When mem_ready is 0, stay in ACCESS with no limit.
- GRANT:
  - grant[id] is 1 and mem_en is 0.
  - The next state is always IDLE. Requests present during GRANT are ignored.
- The non-served core's memdata and grant never change during another core's transaction.
- Changes to a request or its address after it is latched are ignored until the next IDLE.
- Reset, from any state including mid-ACCESS:
  - State goes to IDLE and `last` to 1, so core 0 wins the first tie.
  - All outputs go to 0.
  - An abandoned memory access is dropped, and a mem_ready seen in IDLE or GRANT is ignored.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request seen in IDLE at edge t: mem_en is high from t+1.
- mem_ready high in cycle k: grant pulses in cycle k+1 and memdata[id] is valid from k+1.
- Minimum occupancy per transaction is 3 cycles (IDLE, ACCESS, GRANT) with zero-wait memory, where mem_ready is high in the first ACCESS cycle.
- grant is exactly one cycle wide, and grant0 and grant1 are never high together.
- memdata holds its value until the same core's next read completes.
- Back-to-back service: the earliest a new access can be latched is the IDLE cycle after GRANT. A held competing request is served next, giving fairness with a worst-case wait of one foreign transaction.

## Test plan
- Single read: core 0 memread0=1, adr0=8'h10; memory returns mem_ready=1 with rdata 8'hA5 after 2 cycles. Required: mem_en for 2 cycles with mem_adr=8'h10 and mem_we=0, then grant0 for 1 cycle with memdata0=8'hA5; grant1=0 and memdata1 unchanged.
- Write: core 1 memwrite1=1, adr1=8'h20, writedata1=8'h3C; zero-wait memory. Required: mem_we=1, mem_wdata=8'h3C, grant1 exactly 1 cycle, memdata1 unchanged.
- Simultaneous requests after reset: both cores read. Required: core 0 served first, then core 1; then with both held, the order alternates 0,1,0,1 with no double grant.
- Slow memory: mem_ready held low 10 cycles during a core 0 access while core 1 requests. Required: mem_adr stable for all 10 cycles, no grant1 until core 0's grant has completed, and core 1 serviced next.
- Reset in ACCESS: reset=1 for one cycle mid-transaction, then mem_ready=1. Required: all outputs 0 the cycle after reset, the stray mem_ready ignored with no grant, and the next tie won by core 0.
- Read and write both high on core 0: required mem_we=1 for the access.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin memory arbiter: serialises core 0 / core 1 accesses onto one
// shared memory port, one access in flight, with a ready handshake and a one-cycle grant.
//
// state  | meaning
// IDLE   | no access in flight; pick a winner and latch its request
// ACCESS | mem_en high, waiting for mem_ready
// GRANT  | one-cycle completion pulse to the served core
module mem_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread0,
    input  logic             memwrite0,
    input  logic [WIDTH-1:0] adr0,
    input  logic [WIDTH-1:0] writedata0,
    input  logic             memread1,
    input  logic             memwrite1,
    input  logic [WIDTH-1:0] adr1,
    input  logic [WIDTH-1:0] writedata1,
    output logic             grant0,
    output logic             grant1,
    output logic [WIDTH-1:0] memdata0,
    output logic [WIDTH-1:0] memdata1,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        GRANT  = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;
    logic             id_q;
    logic             grant0_q;
    logic             grant1_q;
    logic [WIDTH-1:0] memdata0_q;
    logic [WIDTH-1:0] memdata1_q;
    logic             mem_en_q;
    logic             mem_we_q;
    logic [WIDTH-1:0] mem_adr_q;
    logic [WIDTH-1:0] mem_wdata_q;

    logic             req0;
    logic             req1;
    logic             win_d;
    logic             we_d;
    logic [WIDTH-1:0] adr_d;
    logic [WIDTH-1:0] wdata_d;

    // On a tie the core that was not served last wins; read+write together counts as a write.
    always_comb begin
        req0    = memread0 | memwrite0;
        req1    = memread1 | memwrite1;
        win_d   = (req0 && req1) ? ~last_q : ~req0;
        we_d    = win_d ? memwrite1 : memwrite0;
        adr_d   = win_d ? adr1 : adr0;
        wdata_d = win_d ? writedata1 : writedata0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            grant0_q    <= 1'b0;
            grant1_q    <= 1'b0;
            memdata0_q  <= '0;
            memdata1_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        id_q        <= win_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= we_d;
                        mem_adr_q   <= adr_d;
                        mem_wdata_q <= wdata_d;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!mem_we_q) begin
                            if (id_q) memdata1_q <= mem_rdata;
                            else      memdata0_q <= mem_rdata;
                        end
                        grant0_q <= ~id_q;
                        grant1_q <= id_q;
                        last_q   <= id_q;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    grant0_q <= 1'b0;
                    grant1_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant0    = grant0_q;
    assign grant1    = grant1_q;
    assign memdata0  = memdata0_q;
    assign memdata1  = memdata1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every cycle, plus
// directed scenarios with hand-computed expectations. Memory returns rdata = adr ^ 8'hB5.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       memread0, memwrite0, memread1, memwrite1;
    logic [7:0] adr0, writedata0, adr1, writedata1;
    logic       grant0, grant1, mem_en, mem_we, mem_ready;
    logic [7:0] memdata0, memdata1, mem_adr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .memread0(memread0), .memwrite0(memwrite0), .adr0(adr0), .writedata0(writedata0),
        .memread1(memread1), .memwrite1(memwrite1), .adr1(adr1), .writedata1(writedata1),
        .grant0(grant0), .grant1(grant1), .memdata0(memdata0), .memdata1(memdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Memory: answers on the lat-th cycle of an access; ready_ovr injects stray ready.
    int   lat = 1;
    int   mcnt = 0;
    logic ready_ovr = 1'b0;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
    end
    always @(negedge clk) begin
        if (mem_en === 1'b1) mcnt = mcnt + 1;
        else                 mcnt = 0;
        mem_ready = ready_ovr || (mem_en === 1'b1 && mcnt == lat);
        mem_rdata = mem_adr ^ 8'hB5;
    end

    // Reference model: a transaction is accepted, waits for ready, then announces itself.
    bit         m_valid = 1'b0;
    bit         m_busy, m_announce, m_last, m_id;
    logic       m_g0, m_g1, m_en, m_we;
    logic [7:0] m_adr, m_wd;
    logic [7:0] m_md [2];

    always @(posedge clk) begin
        bit r0, r1;
        r0 = memread0 | memwrite0;
        r1 = memread1 | memwrite1;
        if (reset) begin
            m_valid = 1'b1; m_busy = 1'b0; m_announce = 1'b0; m_last = 1'b1; m_id = 1'b0;
            m_g0 = 1'b0; m_g1 = 1'b0; m_en = 1'b0; m_we = 1'b0;
            m_adr = 8'h00; m_wd = 8'h00; m_md[0] = 8'h00; m_md[1] = 8'h00;
        end else if (m_announce) begin
            m_announce = 1'b0;
            m_g0 = 1'b0;
            m_g1 = 1'b0;
        end else if (m_busy) begin
            if (mem_ready) begin
                if (!m_we) m_md[m_id] = mem_rdata;
                m_g0 = (m_id == 1'b0);
                m_g1 = (m_id == 1'b1);
                m_last = m_id;
                m_busy = 1'b0;
                m_announce = 1'b1;
                m_en = 1'b0;
                m_we = 1'b0;
            end
        end else if (r0 || r1) begin
            if (r0 && r1) m_id = !m_last;
            else          m_id = r1;
            m_we  = m_id ? memwrite1 : memwrite0;
            m_adr = m_id ? adr1 : adr0;
            m_wd  = m_id ? writedata1 : writedata0;
            m_en  = 1'b1;
            m_busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({grant0, grant1, mem_en, mem_we, mem_adr, mem_wdata, memdata0, memdata1} !==
                {m_g0, m_g1, m_en, m_we, m_adr, m_wd, m_md[0], m_md[1]}) begin
                errors++;
                $display("FAIL model t=%0t actual g=%b%b en=%b we=%b adr=%h wd=%h md0=%h md1=%h required g=%b%b en=%b we=%b adr=%h wd=%h md0=%h md1=%h",
                         $time, grant0, grant1, mem_en, mem_we, mem_adr, mem_wdata, memdata0, memdata1,
                         m_g0, m_g1, m_en, m_we, m_adr, m_wd, m_md[0], m_md[1]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Wait for any grant; who = -1 when the budget runs out.
    task automatic wait_any(input int budget, output int who);
        who = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (grant0 === 1'b1) begin who = 0; break; end
            if (grant1 === 1'b1) begin who = 1; break; end
        end
    endtask

    task automatic zero_outputs(input string name);
        chk(name, {grant0, grant1, mem_en, mem_we, mem_adr, mem_wdata, memdata0, memdata1}, 32'h0);
        chk({name, "_data"}, {memdata0, memdata1, mem_adr, mem_wdata}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int who, en_cnt, adr_bad, early_g1, got;
        reset = 1'b1;
        memread0 = 0; memwrite0 = 0; adr0 = 0; writedata0 = 0;
        memread1 = 0; memwrite1 = 0; adr1 = 0; writedata1 = 0;
        repeat (2) @(negedge clk);
        zero_outputs("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // Single read, memory answers on the second ACCESS cycle
        lat = 2; memread0 = 1; adr0 = 8'h10;
        en_cnt = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                chk("t1_adr", mem_adr, 8'h10);
                chk("t1_we", mem_we, 0);
            end
            if (grant0) begin
                got = 1;
                chk("t1_md0", memdata0, 8'hA5);
                chk("t1_g1", grant1, 0);
                chk("t1_md1", memdata1, 8'h00);
                memread0 = 0;
                break;
            end
        end
        chk("t1_granted", got, 1);
        chk("t1_en_cycles", en_cnt, 2);
        @(negedge clk);
        chk("t1_grant_width", grant0, 0);

        // Write from core 1, zero-wait memory
        lat = 1; memwrite1 = 1; adr1 = 8'h20; writedata1 = 8'h3C;
        en_cnt = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en) begin
                en_cnt++;
                chk("t2_we", mem_we, 1);
                chk("t2_wdata", mem_wdata, 8'h3C);
                chk("t2_adr", mem_adr, 8'h20);
            end
            if (grant1) begin got = 1; memwrite1 = 0; break; end
        end
        chk("t2_granted", got, 1);
        chk("t2_en_cycles", en_cnt, 1);
        chk("t2_md1", memdata1, 8'h00);
        @(negedge clk);
        chk("t2_grant_width", grant1, 0);

        // Ties right after reset: 0 first, then strict alternation
        reset = 1; @(negedge clk); reset = 0;
        memread0 = 1; adr0 = 8'h30; memread1 = 1; adr1 = 8'h40;
        for (int k = 0; k < 6; k++) begin
            wait_any(10, who);
            chk("t3_order", who, k % 2);
        end
        memread0 = 0; memread1 = 0;
        chk("t3_md0", memdata0, 8'h85);
        chk("t3_md1", memdata1, 8'hF5);
        repeat (2) @(negedge clk);

        // Slow memory: ten not-ready cycles while core 1 waits
        lat = 11; memread0 = 1; adr0 = 8'h50;
        en_cnt = 0; adr_bad = 0; early_g1 = 0; got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin memread1 = 1; adr1 = 8'h60; adr0 = 8'h55; end
            if (mem_en) begin
                en_cnt++;
                if (mem_adr !== 8'h50) adr_bad++;
            end
            if (grant1) early_g1++;
            if (grant0) begin got = 1; break; end
        end
        chk("t4_granted0", got, 1);
        chk("t4_en_cycles", en_cnt, 11);
        chk("t4_adr_stable", adr_bad, 0);
        chk("t4_no_early_g1", early_g1, 0);
        chk("t4_md0", memdata0, 8'hE5);
        memread0 = 0; lat = 1;
        wait_any(10, who);
        chk("t4_next", who, 1);
        chk("t4_md1", memdata1, 8'hD5);
        memread1 = 0;
        repeat (2) @(negedge clk);

        // Reset in the middle of an access, then a stray ready
        lat = 100; memread0 = 1; adr0 = 8'h70;
        repeat (3) @(negedge clk);
        chk("t5_in_access", mem_en, 1);
        reset = 1; memread0 = 0;
        @(negedge clk);
        reset = 0; ready_ovr = 1;
        zero_outputs("t5_after_reset");
        wait_any(4, who);
        chk("t5_stray_ignored", who, -1);
        ready_ovr = 0; lat = 1;
        @(negedge clk);
        memread0 = 1; adr0 = 8'h11; memread1 = 1; adr1 = 8'h22;
        wait_any(10, who);
        chk("t5_tie_winner", who, 0);
        memread0 = 0;
        wait_any(10, who);
        chk("t5_second", who, 1);
        memread1 = 0;
        chk("t5_md0", memdata0, 8'hA4);
        repeat (2) @(negedge clk);

        // Read and write both asserted on core 0 is a write
        memread0 = 1; memwrite0 = 1; adr0 = 8'h33; writedata0 = 8'h44;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_en) begin
                got = 1;
                chk("t6_we", mem_we, 1);
                chk("t6_wdata", mem_wdata, 8'h44);
            end
            if (grant0) break;
        end
        chk("t6_saw_access", got, 1);
        chk("t6_md0_kept", memdata0, 8'hA4);
        memread0 = 0; memwrite0 = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
